// File: rtl/etc_tile_seq_if.sv
// rtl/etc_tile_seq_if.sv - job, tile stream, core and result signals of the tile sequencer
interface etc_tile_seq_if #(
    parameter int W  = 16,
    parameter int KW = 8
);
    logic              start;
    logic [1:0]        op_in;
    logic [KW-1:0]     num_k;
    logic              tile_valid;
    logic              tile_ready;
    logic [16*W-1:0]   tile_a;
    logic [16*W-1:0]   tile_b;
    logic [1:0]        core_op;
    logic [16*W-1:0]   core_a;
    logic [16*W-1:0]   core_b;
    logic [16*W-1:0]   core_out;
    logic              res_valid;
    logic              res_ready;
    logic [16*W-1:0]   res_data;
    logic              busy;
    logic              err;

    // sequencer side
    modport master (
        input  start, op_in, num_k, tile_valid, tile_a, tile_b, core_out, res_ready,
        output tile_ready, core_op, core_a, core_b, res_valid, res_data, busy, err
    );

    // fetch logic, tensor core and result consumer side
    modport slave (
        output start, op_in, num_k, tile_valid, tile_a, tile_b, core_out, res_ready,
        input  tile_ready, core_op, core_a, core_b, res_valid, res_data, busy, err
    );
endinterface

// File: rtl/etc_tile_seq.sv
// rtl/etc_tile_seq.sv - feeds k tile pairs to the 4x4 tensor core and reduces its partials
module etc_tile_seq #(
    parameter int W  = 16,
    parameter int KW = 8
) (
    input  logic               clk,
    input  logic               rst,
    etc_tile_seq_if.master     bus
);
    localparam int TW = 16 * W;

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, OUT} state_t;

    state_t          state;
    logic [KW-1:0]   num_k_lat;
    logic [KW-1:0]   issued;
    logic [KW-1:0]   recv;
    logic            v0;
    logic            v1;
    logic [TW-1:0]   acc;
    logic [TW-1:0]   reduced;
    logic [1:0]      core_op_r;
    logic            tile_ready_r;
    logic            res_valid_r;
    logic            busy_r;
    logic            err_r;
    logic            accept;

    assign accept         = bus.tile_valid & tile_ready_r;
    assign bus.tile_ready = tile_ready_r;
    assign bus.res_valid  = res_valid_r;
    assign bus.res_data   = acc;
    assign bus.busy       = busy_r;
    assign bus.err        = err_r;
    assign bus.core_op    = core_op_r;
    // Idle cycles present zero tiles so the core never sees stale operands.
    assign bus.core_a     = accept ? bus.tile_a : '0;
    assign bus.core_b     = accept ? bus.tile_b : '0;

    // Combine the running accumulator with the incoming partial: add for GEMM, unsigned min for APSP.
    always_comb begin
        reduced = '0;
        for (int e = 0; e < 16; e++) begin
            if (core_op_r == 2'd0) begin
                reduced[e*W +: W] = acc[e*W +: W] + bus.core_out[e*W +: W];
            end else if (bus.core_out[e*W +: W] < acc[e*W +: W]) begin
                reduced[e*W +: W] = bus.core_out[e*W +: W];
            end else begin
                reduced[e*W +: W] = acc[e*W +: W];
            end
        end
    end

    // Job FSM, core pipeline tracker and result accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            num_k_lat    <= '0;
            issued       <= '0;
            recv         <= '0;
            v0           <= 1'b0;
            v1           <= 1'b0;
            acc          <= '0;
            core_op_r    <= 2'd0;
            tile_ready_r <= 1'b0;
            res_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            err_r <= 1'b0;
            // Core output for a tile accepted at edge E is ready to sample at E+2.
            v0    <= accept;
            v1    <= v0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.num_k != '0) begin
                            num_k_lat    <= bus.num_k;
                            core_op_r    <= bus.op_in;
                            issued       <= '0;
                            recv         <= '0;
                            tile_ready_r <= 1'b1;
                            busy_r       <= 1'b1;
                            state        <= FEED;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                FEED: begin
                    if (accept) begin
                        issued <= issued + 1'b1;
                        if (issued + 1'b1 == num_k_lat) begin
                            tile_ready_r <= 1'b0;
                            state        <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                end
                OUT: begin
                    if (bus.res_ready) begin
                        res_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // The final receive always lands after the final accept, so it can safely override the state.
            if (v1 && state != IDLE) begin
                acc  <= (recv == '0) ? bus.core_out : reduced;
                recv <= recv + 1'b1;
                if (recv + 1'b1 == num_k_lat) begin
                    tile_ready_r <= 1'b0;
                    res_valid_r  <= 1'b1;
                    state        <= OUT;
                end
            end
        end
    end
endmodule

// File: tb/tb_etc_tile_seq.sv
// tb/tb_etc_tile_seq.sv - directed bench for etc_tile_seq with a behavioural 4x4 tensor core
module tb_etc_tile_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    logic [255:0] core_ra = '0;
    logic [255:0] core_rb = '0;

    etc_tile_seq_if #(.W(16), .KW(8)) bus ();

    etc_tile_seq #(.W(16), .KW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] fill(input logic [15:0] v);
        return {16{v}};
    endfunction

    // Tensor core reference: GEMM or min-plus with the A[i][j] term, all mod 2^16.
    function automatic logic [255:0] core_f(input logic [255:0] a, input logic [255:0] b, input logic [1:0] op);
        logic [255:0] r;
        logic [15:0] s;
        logic [15:0] t;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (op == 2'd0) begin
                    s = '0;
                    for (int k = 0; k < 4; k++) s = s + 16'(a[(4*i+k)*16 +: 16] * b[(4*k+j)*16 +: 16]);
                end else begin
                    s = a[(4*i+j)*16 +: 16];
                    for (int k = 0; k < 4; k++) begin
                        t = a[(4*i+k)*16 +: 16] + b[(4*k+j)*16 +: 16];
                        if (t < s) s = t;
                    end
                end
                r[(4*i+j)*16 +: 16] = s;
            end
        end
        return r;
    endfunction

    // Two-stage core: operands registered at E, result registered at E+1 with op seen at E+1.
    always @(posedge clk) begin
        core_ra      <= bus.core_a;
        core_rb      <= bus.core_b;
        bus.core_out <= core_f(core_ra, core_rb, bus.core_op);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_res(input string tag);
        for (int i = 0; i < 64 && bus.res_valid !== 1'b1; i++) tick();
        chk({tag, "_res_valid"}, 256'(bus.res_valid), 256'd1);
        bus.tile_valid = 1'b0;
    endtask

    task automatic pop(input string tag);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk({tag, "_drop"}, 256'(bus.res_valid), 256'd0);
        chk({tag, "_idle"}, 256'(bus.busy), 256'd0);
    endtask

    task automatic run_job(input logic [1:0] op, input logic [7:0] n, input logic [255:0] a, input logic [255:0] b);
        bus.op_in      = op;
        bus.num_k      = n;
        bus.tile_a     = a;
        bus.tile_b     = b;
        bus.tile_valid = 1'b1;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        logic [255:0] ident;
        logic [255:0] arb;
        int accepts;
        bit seen;

        bus.start = 1'b0; bus.op_in = 2'd0; bus.num_k = 8'd0;
        bus.tile_valid = 1'b0; bus.tile_a = '0; bus.tile_b = '0; bus.res_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_tile_ready", 256'(bus.tile_ready), 256'd0);
        chk("rst_res_valid", 256'(bus.res_valid), 256'd0);
        chk("rst_busy", 256'(bus.busy), 256'd0);
        chk("rst_err", 256'(bus.err), 256'd0);
        chk("rst_res_data", bus.res_data, 256'd0);
        chk("rst_core_op", 256'(bus.core_op), 256'd0);
        chk("rst_core_a", bus.core_a, 256'd0);

        // GEMM, 3 tiles of ones x twos: 3 * 8 = 0x18 per element, result 2 edges after the last accept
        run_job(2'd0, 8'd3, fill(16'd1), fill(16'd2));
        chk("g_busy", 256'(bus.busy), 256'd1);
        chk("g_ready", 256'(bus.tile_ready), 256'd1);
        chk("g_core_a", bus.core_a, fill(16'd1));
        tick(); tick(); tick();
        chk("g_ready_after3", 256'(bus.tile_ready), 256'd0);
        chk("g_core_a_zero", bus.core_a, 256'd0);
        chk("g_rv_n", 256'(bus.res_valid), 256'd0);
        tick();
        chk("g_rv_n1", 256'(bus.res_valid), 256'd0);
        tick();
        chk("g_rv_n2", 256'(bus.res_valid), 256'd1);
        chk("g_data", bus.res_data, fill(16'h0018));
        bus.tile_valid = 1'b0;
        pop("g");

        // APSP, 2 tiles (partials 5 then 1 -> 1); a start during FEED must be ignored
        run_job(2'd1, 8'd2, fill(16'd5), fill(16'd3));
        chk("a_core_op", 256'(bus.core_op), 256'd1);
        bus.start = 1'b1; bus.op_in = 2'd0; bus.num_k = 8'd5;
        tick();
        bus.start = 1'b0;
        bus.tile_a = fill(16'd1); bus.tile_b = fill(16'd1);
        chk("a_no_err", 256'(bus.err), 256'd0);
        chk("a_core_op_held", 256'(bus.core_op), 256'd1);
        tick();
        chk("a_ready_after2", 256'(bus.tile_ready), 256'd0);
        wait_res("a");
        chk("a_data", bus.res_data, fill(16'h0001));
        chk("a_core_op_out", 256'(bus.core_op), 256'd1);
        pop("a");

        // GEMM wraparound: 4 * 0x4000 = 0x10000 -> 0
        run_job(2'd0, 8'd1, fill(16'h4000), fill(16'd1));
        wait_res("w");
        chk("w_data", bus.res_data, 256'd0);
        pop("w");

        // Identity A returns B unchanged
        for (int e = 0; e < 16; e++) begin
            ident[e*16 +: 16] = (e % 5 == 0) ? 16'd1 : 16'd0;
            arb[e*16 +: 16]   = 16'(40960 + e * 291);
        end
        run_job(2'd0, 8'd1, ident, arb);
        wait_res("id");
        chk("id_data", bus.res_data, arb);
        pop("id");

        // Bubbles on the tile stream and back-pressure on the result: 4 * 12 = 0x30
        run_job(2'd0, 8'd4, fill(16'd1), fill(16'd3));
        accepts = 0;
        seen = 1'b0;
        for (int c = 0; c < 40 && bus.res_valid !== 1'b1; c++) begin
            bus.tile_valid = (c % 2 == 0);
            if (bus.tile_valid && bus.tile_ready) accepts++;
            tick();
            if (accepts == 4 && !seen) begin
                seen = 1'b1;
                chk("b_ready_low", 256'(bus.tile_ready), 256'd0);
            end
        end
        wait_res("b");
        chk("b_accepts", 256'(accepts), 256'd4);
        for (int c = 0; c < 5; c++) begin
            chk("b_hold_valid", 256'(bus.res_valid), 256'd1);
            chk("b_hold_data", bus.res_data, fill(16'h0030));
            tick();
        end
        pop("b");

        // num_k == 0 is rejected with a single-cycle err
        bus.num_k = 8'd0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("z_err", 256'(bus.err), 256'd1);
        chk("z_busy", 256'(bus.busy), 256'd0);
        tick();
        chk("z_err_gone", 256'(bus.err), 256'd0);
        chk("z_busy2", 256'(bus.busy), 256'd0);

        // Reset one cycle after the 2nd of 3 accepts, then a clean job straight away
        run_job(2'd0, 8'd3, fill(16'd7), fill(16'd7));
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.tile_valid = 1'b0;
        chk("r_busy", 256'(bus.busy), 256'd0);
        chk("r_res_valid", 256'(bus.res_valid), 256'd0);
        chk("r_tile_ready", 256'(bus.tile_ready), 256'd0);
        chk("r_res_data", bus.res_data, 256'd0);
        run_job(2'd0, 8'd1, fill(16'd1), fill(16'd1));
        wait_res("r");
        chk("r_data", bus.res_data, fill(16'h0004));
        pop("r");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
